// File: rtl/bcd_display_scan_if.sv
// ============================================================================
// Module : bcd_display_scan_if
// Brief  : Bundles the BCD load port and the display drive outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_display_scan_if;
    logic [15:0] bcd_in;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;

    modport master (
        output bcd_in,
        output load,
        input  an,
        input  seg
    );

    modport slave (
        input  bcd_in,
        input  load,
        output an,
        output seg
    );
endinterface

`default_nettype wire

// File: rtl/bcd_display_scan.sv
// ============================================================================
// Module : bcd_display_scan
// Brief  : Four-digit multiplexed common-anode seven-segment scanner for a
//          packed BCD word. Optional macro LEADING_ZERO_BLANK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_display_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bcd_display_scan_if.slave  bus
);

    localparam int                 c_CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);

    localparam logic [1:0] c_DIG0 = 2'd0;
    localparam logic [1:0] c_DIG1 = 2'd1;
    localparam logic [1:0] c_DIG2 = 2'd2;
    localparam logic [1:0] c_DIG3 = 2'd3;

    localparam logic [3:0] c_AN_OFF  = 4'b1111;
    localparam logic [6:0] c_SEG_OFF = 7'b1111111;

    logic [15:0]        r_hold;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_wrap;
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [3:0]         w_nibble;
    logic [3:0]         w_an_next;
    logic [6:0]         w_seg_next;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;

    // {g,f,e,d,c,b,a}, active low; non-decimal codes render as a dash.
    function automatic logic [6:0] f_decode(input logic [3:0] i_digit);
        logic [6:0] v_seg;
        case (i_digit)
            4'd0:    v_seg = 7'b1000000;
            4'd1:    v_seg = 7'b1111001;
            4'd2:    v_seg = 7'b0100100;
            4'd3:    v_seg = 7'b0110000;
            4'd4:    v_seg = 7'b0011001;
            4'd5:    v_seg = 7'b0010010;
            4'd6:    v_seg = 7'b0000010;
            4'd7:    v_seg = 7'b1111000;
            4'd8:    v_seg = 7'b0000000;
            4'd9:    v_seg = 7'b0010000;
            default: v_seg = 7'b0111111;
        endcase
        return v_seg;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold <= 16'h0000;
        end else if (bus.load) begin
            r_hold <= bus.bcd_in;
        end
    end

    assign w_wrap = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_DIG0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_wrap) begin
            case (r_state)
                c_DIG0:  w_state_next = c_DIG1;
                c_DIG1:  w_state_next = c_DIG2;
                c_DIG2:  w_state_next = c_DIG3;
                c_DIG3:  w_state_next = c_DIG0;
                default: w_state_next = c_DIG0;
            endcase
        end
    end

    always_comb begin
        w_nibble   = r_hold[3:0];
        w_an_next  = c_AN_OFF;
        w_seg_next = c_SEG_OFF;
        case (r_state)
            c_DIG0:  begin w_nibble = r_hold[3:0];   w_an_next = 4'b1110; end
            c_DIG1:  begin w_nibble = r_hold[7:4];   w_an_next = 4'b1101; end
            c_DIG2:  begin w_nibble = r_hold[11:8];  w_an_next = 4'b1011; end
            c_DIG3:  begin w_nibble = r_hold[15:12]; w_an_next = 4'b0111; end
            default: begin w_nibble = r_hold[3:0];   w_an_next = 4'b1110; end
        endcase
        w_seg_next = f_decode(w_nibble);
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is blank only when it and every more significant digit are zero.
        case (r_state)
            c_DIG1:  if (r_hold[15:4]  == 12'h000) begin w_an_next = c_AN_OFF; w_seg_next = c_SEG_OFF; end
            c_DIG2:  if (r_hold[15:8]  == 8'h00)   begin w_an_next = c_AN_OFF; w_seg_next = c_SEG_OFF; end
            c_DIG3:  if (r_hold[15:12] == 4'h0)    begin w_an_next = c_AN_OFF; w_seg_next = c_SEG_OFF; end
            default: ;
        endcase
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an  <= c_AN_OFF;
            r_seg <= c_SEG_OFF;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
// ============================================================================
// Module : tb_bcd_display_scan
// Brief  : Self-checking bench with a frame-position reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_display_scan;
    localparam int DIV = 4;

    logic clk;
    logic rst_n;
    bcd_display_scan_if bus ();

    bcd_display_scan #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [6:0] segtab [16];
    initial segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                       7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                       7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    // Literal expectations posted by the stimulus process for the next edge.
    string      lit_name = "";
    logic [3:0] lit_an   = 4'hF;
    logic [6:0] lit_seg  = 7'h7F;
    int         lit_seq  = 0;
    int         lit_seen = 0;

    longint     m_pos   = 0;
    logic [15:0] m_hold = 16'h0;
    bit         m_valid = 1'b0;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int         dig;
    logic [3:0] one4 = 4'b0001;
    logic       s_rst_n, s_load;
    logic [15:0] s_bcd;

    always @(posedge clk) begin
        s_rst_n = rst_n;
        s_load  = bus.load;
        s_bcd   = bus.bcd_in;
        if (!s_rst_n) begin
            e_an    = 4'hF;
            e_seg   = 7'h7F;
            m_pos   = 0;
            m_hold  = 16'h0;
            m_valid = 1'b1;
        end else begin
            dig   = int'((m_pos / DIV) % 4);
            e_an  = ~(one4 << dig);
            e_seg = segtab[(m_hold >> (4 * dig)) & 16'hF];
`ifdef LEADING_ZERO_BLANK_EN
            if (dig != 0 && (m_hold >> (4 * dig)) == 16'h0) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
            end
`endif
            m_pos = m_pos + 1;
            if (s_load) m_hold = s_bcd;
        end
        #1;
        if (m_valid) begin
            total = total + 1;
            if (bus.an !== e_an || bus.seg !== e_seg) begin
                bad = bad + 1;
                $display("FAIL model t=%0t an=%b seg=%b expected an=%b seg=%b",
                         $time, bus.an, bus.seg, e_an, e_seg);
            end
        end
        if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            total = total + 1;
            if (bus.an !== lit_an || bus.seg !== lit_seg) begin
                bad = bad + 1;
                $display("FAIL %s t=%0t an=%b seg=%b expected an=%b seg=%b",
                         lit_name, $time, bus.an, bus.seg, lit_an, lit_seg);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_next(input string name, input logic [3:0] a, input logic [6:0] s);
        lit_name = name;
        lit_an   = a;
        lit_seg  = s;
        lit_seq  = lit_seq + 1;
        cyc();
    endtask

    // Returns aligned to the first edge of the slot whose anode pattern is a.
    task automatic wait_slot(input logic [3:0] a);
        int n = 0;
        while (bus.an == a) begin
            cyc(); n++;
            if (n > 64) begin $display("FAIL wait_slot timeout an=%b", bus.an); $fatal(1); end
        end
        while (bus.an != a) begin
            cyc(); n++;
            if (n > 64) begin $display("FAIL wait_slot timeout an=%b", bus.an); $fatal(1); end
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load   = 1'b1;
        bus.bcd_in = v;
        cyc();
        bus.load   = 1'b0;
    endtask

    logic [3:0] scan_an  [4];
    logic [6:0] scan_seg [4];

    initial begin
        scan_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        scan_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        rst_n      = 1'b0;
        bus.load   = 1'b0;
        bus.bcd_in = 16'h0;

        for (int i = 0; i < 3; i++) expect_next("reset", 4'b1111, 7'b1111111);
        rst_n = 1'b1;
        expect_next("first_after_reset", 4'b1110, 7'b1000000);

        do_load(16'h1234);
        wait_slot(4'b1110);
        for (int i = 1; i < 16; i++) expect_next("scan_1234", scan_an[i / 4], scan_seg[i / 4]);

        do_load(16'h00F9);
        wait_slot(4'b1110);
        for (int i = 1; i < 4; i++) expect_next("invalid_units", 4'b1110, 7'b0010000);
        expect_next("invalid_tens", 4'b1101, 7'b0111111);

        do_load(16'h1234);
        wait_slot(4'b1101);
        expect_next("tens_e1", 4'b1101, 7'b0110000);
        bus.load   = 1'b1;
        bus.bcd_in = 16'h5678;
        expect_next("tens_e2", 4'b1101, 7'b0110000);
        bus.load   = 1'b0;
        expect_next("mid_load", 4'b1101, 7'b1111000);

        do_load(16'h0007);
        wait_slot(4'b1110);
        for (int i = 1; i < 4; i++) expect_next("lz_units", 4'b1110, 7'b1111000);
        for (int i = 4; i < 16; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            expect_next("lz_blank", 4'b1111, 7'b1111111);
`else
            expect_next("lz_zero", scan_an[i / 4], 7'b1000000);
`endif
        end

        for (int i = 0; i < 300; i++) begin
            bus.load   = ($urandom_range(0, 5) == 0);
            bus.bcd_in = 16'($urandom);
            rst_n      = ($urandom_range(0, 96) != 0);
            cyc();
        end
        rst_n    = 1'b1;
        bus.load = 1'b0;

        do_load(16'h9876);
        wait_slot(4'b1011);
        cyc();
        rst_n = 1'b0;
        expect_next("reset_mid", 4'b1111, 7'b1111111);
        rst_n = 1'b1;
        expect_next("resume_dig0", 4'b1110, 7'b1000000);
        for (int i = 0; i < 20; i++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/bcd_display_scan.md
# bcd_display_scan

Four-digit multiplexed seven-segment display driver that consumes the 16-bit packed BCD word produced by the binary-to-BCD conversion stage and drives a common-anode display with active-low anodes and segments. It sits directly downstream of the converter at the output end of the multiplier datapath. It latches a result on a load strobe, then continuously scans the four digits at a rate set by a prescaler.

## Interface
- REFRESH_DIV, default 50000, clock cycles each digit stays enabled; legal range ≥ 1. The prescaler width is $clog2(REFRESH_DIV), minimum 1 bit.
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- bcd_in  in  16  packed BCD word: [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- load  in  1  when high at an edge, bcd_in is captured into the hold register.
- an  out  4  active-low digit enables; an[0] is the units digit. Exactly one bit is low, or none.
- seg  out  7  active-low segments, ordered {g,f,e,d,c,b,a}.

## Operation
- Hold register, 16 bits, reset value 0. Updated only when load=1; otherwise it retains its value. bcd_in is ignored while load=0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. On the wrap cycle (count == REFRESH_DIV-1), the 2-bit digit index advances 0→1→2→3→0.
- Scan state is the digit index. There are four states, DIG0..DIG3, traversed cyclically. There is no idle state, and load never resets the prescaler or the index.
- Decode, with seg given as {g..a}:
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
  - Codes A–F: 0111111 (dash, segment g only).
- an is registered as ~(4'b0001 << index). seg is registered as the decode of hold-register nibble [index].
- Load and a prescaler wrap in the same cycle: both take effect. The next output registration uses the new index and the new hold value.

## Timing
- Reset: when rst_n=0 at an edge, the following hold after that edge:
  - an=4'b1111, seg=7'b1111111.
  - hold=0, prescaler=0, index=0.
- Applying reset mid-scan has the same effect; the scan restarts at DIG0.
- First edge with rst_n=1: an=4'b1110, seg=1000000 (units "0").
- Outputs are registered with 1-cycle latency from index or hold change to an/seg change.
- Load to visible update: the new digit value appears on seg at the first edge after the capture edge at which that digit is selected. The worst case is 3·REFRESH_DIV+1 cycles.
- Each digit is enabled for exactly REFRESH_DIV consecutive cycles. A full frame is 4·REFRESH_DIV cycles.
- REFRESH_DIV=1: the index advances every cycle and the prescaler stays at 0.
- an and seg change on the same edge, so no cycle pairs a new anode with a stale segment pattern.

## Configuration
- Macro LEADING_ZERO_BLANK_EN.
- When defined: a digit at position k ∈ {3,2,1} is blanked when its nibble and all higher nibbles equal 0. When selected, a blanked digit drives an=4'b1111 and seg=7'b1111111. The scan timing is unchanged; blanked slots still last REFRESH_DIV cycles.
  - The units digit is never blanked.
  - Codes A–F count as non-zero.
- When undefined: all four digits are always shown, including leading zeros. The blanking logic is absent.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with REFRESH_DIV=4, then release → an=1111 and seg=1111111 during reset. On the first edge after release, an=1110 and seg=1000000.
- Scan sequence: REFRESH_DIV=4, load 16'h1234 → the bench must observe the following, each slot for 4 cycles, repeating every 16 cycles:
  - an=1110, seg=0011001
  - an=1101, seg=0110000
  - an=1011, seg=0100100
  - an=0111, seg=1111001
- Invalid BCD: load 16'h00F9 → the units slot shows seg=0010000 and the tens slot shows seg=0111111.
- Load mid-scan: with the display showing 16'h1234, load 16'h5678 two cycles into the tens slot → the index is not disturbed. seg changes to 1111000 on the next edge while an stays 1101.
- Leading-zero blanking: load 16'h0007 → with LEADING_ZERO_BLANK_EN, the thousands, hundreds and tens slots give an=1111 and seg=1111111, and units gives seg=1111000. Without the macro, those three slots show seg=1000000.
- Reset mid-scan: assert rst_n=0 for 1 cycle during DIG2 → the next edge gives an=1111 and hold=0. The scan resumes at DIG0, showing "0".
